// File: rtl/bram_frame_pkg.sv
// ============================================================================
// Module : bram_frame_pkg
// Brief  : Shared FSM state type and frame-size helper for bram_frame_reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bram_frame_pkg;

  typedef enum logic {S_IDLE, S_RUN} rd_state_t;

  localparam int DEF_MAX_COL = 540;
  localparam int DEF_MAX_ROW = 360;

  function automatic int frame_pix(input int max_col, input int max_row);
    return max_col * max_row;
  endfunction

  localparam int LAST_PIX = frame_pix(DEF_MAX_COL, DEF_MAX_ROW) - 1;

endpackage

`default_nettype wire

// File: rtl/lat_pipe.sv
// ============================================================================
// Module : lat_pipe
// Brief  : Valid-bit shift register of DEPTH stages with synchronous flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] pipe_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pipe_q <= '0;
        else if (flush_i) pipe_q <= '0;
        else              pipe_q <= valid_i;
      end
    end else begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pipe_q <= '0;
        else if (flush_i) pipe_q <= '0;
        else              pipe_q <= {pipe_q[DEPTH-2:0], valid_i};
      end
    end
  endgenerate

  assign valid_o = pipe_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/bram_frame_reader.sv
// ============================================================================
// Module : bram_frame_reader
// Brief  : Double-buffered BRAM port-B read controller for the VGA pixel path.
//          Optional 2x nearest-neighbour upscale via macro PIX_REPLICATE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_frame_reader
  import bram_frame_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_COL = DEF_MAX_COL,
  parameter int MAX_ROW = DEF_MAX_ROW,
  parameter int ADDR_W  = 19,
  parameter int RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_en_i,
  input  logic              frame_start_i,
  input  logic              buf_sel_i,
  input  logic              bram_en_i,
  output logic              enb_o,
  output logic              web_o,
  output logic [ADDR_W-1:0] addrb_o,
  output logic [DATA_W-1:0] d2memb_o,
  input  logic [DATA_W-1:0] mem2db_i,
  output logic [DATA_W-1:0] RGB_o,
  output logic              RGB_en_o,
  output logic              frame_done_o,
  output logic              buf_cur_o
);

  localparam int              FRAME_PIX  = frame_pix(MAX_COL, MAX_ROW);
  localparam logic [ADDR_W-1:0] FRAME_ADDR = ADDR_W'(FRAME_PIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  rd_state_t         state_q, state_d;
  logic              buf_cur_q, buf_cur_d;
  logic [ADDR_W-1:0] pix_q, pix_d;

  logic run, stop, restart, accept, at_last, rgb_valid;

  assign run     = (state_q == S_RUN);
  assign stop    = run && !ctrl_en_i;
  // Covers both the IDLE->RUN launch and a resync while already running.
  assign restart = ctrl_en_i && frame_start_i;
  assign accept  = run && ctrl_en_i && bram_en_i && !frame_start_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ctrl_en_i && frame_start_i) state_d = S_RUN;
      S_RUN:   if (!ctrl_en_i)                 state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

`ifdef PIX_REPLICATE_EN
  localparam int            COL_W    = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAX_COL - 1);

  logic              x_ph_q, x_ph_d, y_ph_q, y_ph_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] line_q, line_d;

  assign at_last = x_ph_q && y_ph_q && (pix_q == LAST_ADDR);

  always_comb begin
    pix_d     = pix_q;
    buf_cur_d = buf_cur_q;
    x_ph_d    = x_ph_q;
    y_ph_d    = y_ph_q;
    col_d     = col_q;
    line_d    = line_q;
    if (stop || restart) begin
      pix_d  = '0;
      x_ph_d = 1'b0;
      y_ph_d = 1'b0;
      col_d  = '0;
      line_d = '0;
      if (!stop) buf_cur_d = buf_sel_i;
    end else if (accept) begin
      x_ph_d = !x_ph_q;
      if (x_ph_q) begin
        if (col_q != LAST_COL) begin
          col_d = col_q + COL_W'(1);
          pix_d = pix_q + ONE;
        end else begin
          col_d  = '0;
          y_ph_d = !y_ph_q;
          if (!y_ph_q) begin
            pix_d = line_q;
          end else if (at_last) begin
            pix_d     = '0;
            line_d    = '0;
            buf_cur_d = buf_sel_i;
          end else begin
            pix_d  = pix_q + ONE;
            line_d = pix_q + ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_ph_q <= 1'b0;
      y_ph_q <= 1'b0;
      col_q  <= '0;
      line_q <= '0;
    end else begin
      x_ph_q <= x_ph_d;
      y_ph_q <= y_ph_d;
      col_q  <= col_d;
      line_q <= line_d;
    end
  end
`else
  assign at_last = (pix_q == LAST_ADDR);

  always_comb begin
    pix_d     = pix_q;
    buf_cur_d = buf_cur_q;
    if (stop) begin
      pix_d = '0;
    end else if (restart) begin
      pix_d     = '0;
      buf_cur_d = buf_sel_i;
    end else if (accept) begin
      if (at_last) begin
        pix_d     = '0;
        buf_cur_d = buf_sel_i;
      end else begin
        pix_d = pix_q + ONE;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q     <= '0;
      buf_cur_q <= 1'b0;
    end else begin
      pix_q     <= pix_d;
      buf_cur_q <= buf_cur_d;
    end
  end

  lat_pipe #(.DEPTH(RD_LAT)) u_lat_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (stop),
    .valid_i (accept),
    .valid_o (rgb_valid)
  );

  assign enb_o        = accept;
  assign web_o        = 1'b0;
  assign d2memb_o     = '0;
  assign addrb_o      = (buf_cur_q ? FRAME_ADDR : '0) + pix_q;
  assign frame_done_o = accept && at_last;
  assign buf_cur_o    = buf_cur_q;
  assign RGB_en_o     = rgb_valid;
  assign RGB_o        = rgb_valid ? mem2db_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_bram_frame_reader.sv
// ============================================================================
// Module : tb_bram_frame_reader
// Brief  : Directed scoreboard bench for bram_frame_reader (3x2 frame, RD_LAT=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bram_frame_reader;

  localparam int DATA_W = 8, MAX_COL = 3, MAX_ROW = 2, ADDR_W = 4, RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n, ctrl_en_i, frame_start_i, buf_sel_i, bram_en_i;
  logic              enb_o, web_o, RGB_en_o, frame_done_o, buf_cur_o;
  logic [ADDR_W-1:0] addrb_o, a1_q, a2_q;
  logic [DATA_W-1:0] d2memb_o, mem2db_i, RGB_o;

  typedef struct { int cyc; int data; } exp_t;
  exp_t sb[$];
  int   checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_frame_reader #(
    .DATA_W(DATA_W), .MAX_COL(MAX_COL), .MAX_ROW(MAX_ROW),
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en_i(ctrl_en_i), .frame_start_i(frame_start_i),
    .buf_sel_i(buf_sel_i), .bram_en_i(bram_en_i), .enb_o(enb_o), .web_o(web_o),
    .addrb_o(addrb_o), .d2memb_o(d2memb_o), .mem2db_i(mem2db_i), .RGB_o(RGB_o),
    .RGB_en_o(RGB_en_o), .frame_done_o(frame_done_o), .buf_cur_o(buf_cur_o)
  );

  function automatic logic [DATA_W-1:0] datf(input int a);
    return DATA_W'(8'h31 + a * 13);
  endfunction

  // Two-stage BRAM model: data for the address of cycle T is on the bus in T+2.
  always @(posedge clk) begin
    a1_q <= addrb_o;
    a2_q <= a1_q;
  end
  assign mem2db_i = datf(int'(a2_q));

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (RGB_en_o) begin
        if (sb.size() == 0) chk("rgb_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rgb_latency", cyc, e.cyc);
          chk("rgb_data", int'(RGB_o), e.data);
        end
      end else begin
        chk("rgb_zero", int'(RGB_o), 0);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          chk("rgb_missing", 0, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  // One cycle: drive at posedge+1, check combinational outputs at negedge.
  task automatic step(input logic fs, input logic be, input logic exp_enb,
                      input int exp_addr, input logic exp_done, input string nm);
    frame_start_i = fs;
    bram_en_i     = be;
    @(negedge clk);
    chk({nm, "_enb"}, int'(enb_o), int'(exp_enb));
    chk({nm, "_done"}, int'(frame_done_o), int'(exp_done));
    if (exp_enb) begin
      chk({nm, "_addr"}, int'(addrb_o), exp_addr);
      sb.push_back('{cyc: cyc + RD_LAT, data: int'(datf(exp_addr))});
    end
    @(posedge clk); #1;
    frame_start_i = 1'b0;
    bram_en_i     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_enb", int'(enb_o), 0);
      @(posedge clk); #1;
    end
  endtask

`ifdef PIX_REPLICATE_EN
  int rep [24] = '{0,0,1,1,2,2, 0,0,1,1,2,2, 3,3,4,4,5,5, 3,3,4,4,5,5};
`endif

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ctrl_en_i = 1'b0; frame_start_i = 1'b0; buf_sel_i = 1'b0; bram_en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset asserted mid-RUN with buffer 1 selected.
    ctrl_en_i = 1'b1; buf_sel_i = 1'b1;
    step(1, 0, 0, 0, 0, "t1_start");
    chk("t1_bufcur_run", int'(buf_cur_o), 1);
    step(0, 1, 1, 6, 0, "t1_req");
    rst_n = 1'b0; bram_en_i = 1'b1;
    sb.delete();
    #2;
    chk("rst_enb", int'(enb_o), 0);
    chk("rst_addr", int'(addrb_o), 0);
    chk("rst_rgb_en", int'(RGB_en_o), 0);
    chk("rst_rgb", int'(RGB_o), 0);
    chk("rst_done", int'(frame_done_o), 0);
    chk("rst_bufcur", int'(buf_cur_o), 0);
    chk("rst_web", int'(web_o), 0);
    chk("rst_d2mem", int'(d2memb_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; bram_en_i = 1'b0; buf_sel_i = 1'b0;
    step(0, 1, 0, 0, 0, "t1_pre0");
    step(0, 1, 0, 0, 0, "t1_pre1");
    idle(3);

`ifndef PIX_REPLICATE_EN
    // Buffer 0, one full frame.
    step(1, 0, 0, 0, 0, "t2_start");
    chk("t2_bufcur", int'(buf_cur_o), 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, i, (i == 5), "t2_req");
    chk("t2_bufcur_wrap", int'(buf_cur_o), 0);

    // Buffer select changes mid-frame; takes effect only at wrap.
    step(0, 1, 1, 0, 0, "t3_req");
    step(0, 1, 1, 1, 0, "t3_req");
    buf_sel_i = 1'b1;
    step(0, 1, 1, 2, 0, "t3_req");
    chk("t3_bufcur_mid", int'(buf_cur_o), 0);
    step(0, 1, 1, 3, 0, "t3_req");
    step(0, 1, 1, 4, 0, "t3_req");
    idle(1);
    step(0, 1, 1, 5, 1, "t3_req");
    chk("t3_bufcur_new", int'(buf_cur_o), 1);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 6 + i, (i == 5), "t3_buf1");

    // Frame start coinciding with a request at pix 3.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 6 + i, 0, "t4_req");
    buf_sel_i = 1'b0;
    step(1, 1, 0, 0, 0, "t4_fs_drop0");
    chk("t4_bufcur0", int'(buf_cur_o), 0);
    step(0, 1, 1, 0, 0, "t4_after0");
    buf_sel_i = 1'b1;
    step(0, 1, 1, 1, 0, "t4_req");
    step(1, 1, 0, 0, 0, "t4_fs_drop1");
    chk("t4_bufcur1", int'(buf_cur_o), 1);
    step(0, 1, 1, 6, 0, "t4_after1");
    step(0, 1, 1, 7, 0, "t4_req");

    // ctrl_en_i dropped with two reads in flight.
    step(0, 1, 1, 8, 0, "t5_req");
    step(0, 1, 1, 9, 0, "t5_req");
    ctrl_en_i = 1'b0;
    @(negedge clk);
    chk("t5_drop_enb", int'(enb_o), 0);
    @(posedge clk); #1;
    sb.delete();
    ctrl_en_i = 1'b1; bram_en_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_flush_rgb_en", int'(RGB_en_o), 0);
      chk("t5_idle_enb", int'(enb_o), 0);
      @(posedge clk); #1;
    end
    bram_en_i = 1'b0;
    step(1, 0, 0, 0, 0, "t5_restart");
    step(0, 1, 1, 6, 0, "t5_after");
    step(0, 1, 1, 7, 0, "t5_after");
`else
    // 2x upscale: 24 requests per frame.
    step(1, 0, 0, 0, 0, "t6_start");
    for (int i = 0; i < 24; i++) step(0, 1, 1, rep[i], (i == 23), "t6_req");
    step(0, 1, 1, 0, 0, "t6_wrap");
`endif

    idle(RD_LAT + 2);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
